dbus_lsu: RTL and testbench

Data-bus load/store unit between the pipeline's memory stage and the external data bus (DAD/MREQ/WRITE/SIZE/DDT/ACKD_n). It accepts one load or store request at a time and checks alignment. It runs the bus handshake with a timeout watchdog, places store data on the correct byte lanes, and sign- or zero-extends load data before returning it to the core. While a transaction is in flight it holds the pipeline via `busy`.

---
 rtl/dbus_lsu.sv | 200 ++++++++++++++++++++
 tb/tb_dbus_lsu.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_lsu.sv
// dbus_lsu: data-bus load/store unit between the memory stage and the
// external data bus, with alignment check, lane placement and load extension.
module dbus_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int BIT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [BIT_WIDTH-1:0] rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    input  logic                 ACKD_n
);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [BIT_WIDTH-1:0] addr_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [BIT_WIDTH-1:0] rdata_q;
    logic [1:0]           size_q;
    logic                 write_q;
    logic                 uns_q;
    logic [1:0]           err_q;
    logic [15:0]          cnt_q;

    logic                 misalign;
    logic                 tmo_hit;
    logic                 ddt_oe;
    logic [BIT_WIDTH-1:0] st_lanes;
    logic [BIT_WIDTH-1:0] ld_ext;

    assign tmo_hit = (cnt_q == TMO_LAST);

    // Alignment and size legality of the request presented this cycle
    always_comb begin
        misalign = 1'b0;
        unique case (req_size)
            SZ_WORD: misalign = |req_addr[1:0];
            SZ_HALF: misalign = req_addr[0];
            SZ_BYTE: misalign = 1'b0;
            SZ_ILL:  misalign = 1'b1;
            default: misalign = 1'b1;
        endcase
    end

    // Store data placed right-aligned on the low lanes, upper lanes zero
    always_comb begin
        st_lanes = '0;
        unique case (1'b1)
            (size_q == SZ_HALF): st_lanes[15:0] = wdata_q[15:0];
            (size_q == SZ_BYTE): st_lanes[7:0]  = wdata_q[7:0];
            default:             st_lanes       = wdata_q;
        endcase
    end

    // Sign or zero extension of the incoming bus data for loads
    always_comb begin
        ld_ext = DDT;
        unique case (1'b1)
            (size_q == SZ_HALF):
                ld_ext = {{(BIT_WIDTH-16){~uns_q & DDT[15]}}, DDT[15:0]};
            (size_q == SZ_BYTE):
                ld_ext = {{(BIT_WIDTH-8){~uns_q & DDT[7]}}, DDT[7:0]};
            default: ld_ext = DDT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack takes priority over the timeout limit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = misalign ? RESP : BUS;
                end
            end
            BUS: begin
                if (!ACKD_n || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; bus fields are zero outside BUS
    always_comb begin
        busy      = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = ERR_OK;
        DAD       = '0;
        MREQ      = 1'b0;
        WRITE     = 1'b0;
        SIZE      = SZ_WORD;
        ddt_oe    = 1'b0;
        unique case (state_q)
            IDLE: ;
            BUS: begin
                busy   = 1'b1;
                MREQ   = 1'b1;
                WRITE  = write_q;
                DAD    = addr_q;
                SIZE   = size_q;
                ddt_oe = write_q;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign DDT = ddt_oe ? st_lanes : {BIT_WIDTH{1'bz}};

    // Request latch, wait counter, and load capture / error recording
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= SZ_WORD;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        write_q <= req_write;
                        uns_q   <= req_unsigned;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                        err_q   <= misalign ? ERR_ALIGN : ERR_OK;
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (!ACKD_n) begin
                        err_q <= ERR_OK;
                        if (!write_q) begin
                            rdata_q <= ld_ext;
                        end
                    end else if (tmo_hit) begin
                        err_q <= ERR_TMO;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_lsu.sv
// tb_dbus_lsu: directed self-checking bench for dbus_lsu.
// Each task drives one scenario and compares against hand-computed values.
module tb_dbus_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    wire  [31:0] ddt;
    logic        ACKD_n = 1'b1;

    logic        tb_drv = 1'b0;
    logic [31:0] tb_ddt = '0;

    int n_pass = 0;
    int n_total = 0;

    assign ddt = tb_drv ? tb_ddt : 32'bz;

    dbus_lsu #(
        .TIMEOUT_CYCLES(TO),
        .BIT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .busy(busy),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .DAD(DAD),
        .MREQ(MREQ),
        .WRITE(WRITE),
        .SIZE(SIZE),
        .DDT(ddt),
        .ACKD_n(ACKD_n)
    );

    always #5 clk = ~clk;

    // Presents a request for one cycle; returns 1ns into the next cycle
    task automatic send(input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] d);
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        n_total++;
        if ({MREQ, WRITE, SIZE, DAD} !== 36'h0)
            $display("FAIL reset_bus: got %h want %h",
                     {MREQ, WRITE, SIZE, DAD}, 36'h0);
        else n_pass++;
        n_total++;
        if ({busy, rsp_valid, rsp_err, rsp_rdata} !== 36'h0)
            $display("FAIL reset_rsp: got %h want %h",
                     {busy, rsp_valid, rsp_err, rsp_rdata}, 36'h0);
        else n_pass++;
        tb_drv = 1'b1;
        tb_ddt = 32'h5A5A_A5A5;
        #1;
        n_total++;
        if (ddt !== 32'h5A5A_A5A5)
            $display("FAIL reset_ddt_released: got %h want %h",
                     ddt, 32'h5A5A_A5A5);
        else n_pass++;
        tb_drv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_word_load;
        @(posedge clk); #1;
        send(1'b0, 2'b00, 1'b0, 32'h0800_0000, 32'hFFFF_0000);
        ACKD_n = 1'b0;
        tb_drv = 1'b1;
        tb_ddt = 32'h1234_5678;
        @(negedge clk);
        n_total++;
        if ({busy, MREQ, WRITE, SIZE, DAD, rsp_valid} !==
            {1'b1, 1'b1, 1'b0, 2'b00, 32'h0800_0000, 1'b0})
            $display("FAIL lw_cycle1: got %h want %h",
                     {busy, MREQ, WRITE, SIZE, DAD, rsp_valid},
                     {1'b1, 1'b1, 1'b0, 2'b00, 32'h0800_0000, 1'b0});
        else n_pass++;
        @(posedge clk); #1;
        ACKD_n = 1'b1;
        tb_drv = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata, MREQ, busy} !==
            {1'b1, 2'b00, 32'h1234_5678, 1'b0, 1'b1})
            $display("FAIL lw_rsp: got %h want %h",
                     {rsp_valid, rsp_err, rsp_rdata, MREQ, busy},
                     {1'b1, 2'b00, 32'h1234_5678, 1'b0, 1'b1});
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, busy} !== 2'b00)
            $display("FAIL lw_idle: got %b want %b",
                     {rsp_valid, busy}, 2'b00);
        else n_pass++;
    endtask

    task automatic test_byte_load;
        logic [31:0] exp;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            send(1'b0, 2'b10, (k == 1), 32'h0800_0003, 32'hFFFF_FFFF);
            ACKD_n = 1'b0;
            tb_drv = 1'b1;
            tb_ddt = 32'h0000_0080;
            @(posedge clk); #1;
            ACKD_n = 1'b1;
            tb_drv = 1'b0;
            exp = (k == 1) ? 32'h0000_0080 : 32'hFFFF_FF80;
            @(negedge clk);
            n_total++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 2'b00, exp})
                $display("FAIL byte_load_%0d: got %h want %h", k,
                         {rsp_valid, rsp_err, rsp_rdata},
                         {1'b1, 2'b00, exp});
            else n_pass++;
        end
    endtask

    task automatic test_half_store;
        @(posedge clk); #1;
        send(1'b1, 2'b01, 1'b0, 32'h0800_0006, 32'hDEAD_BEEF);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) ACKD_n = 1'b0;
            @(negedge clk);
            n_total++;
            if ({MREQ, WRITE, SIZE, DAD, ddt, rsp_valid} !==
                {1'b1, 1'b1, 2'b01, 32'h0800_0006, 32'h0000_BEEF, 1'b0})
                $display("FAIL sh_bus_c%0d: got %h want %h", c,
                         {MREQ, WRITE, SIZE, DAD, ddt, rsp_valid},
                         {1'b1, 1'b1, 2'b01, 32'h0800_0006,
                          32'h0000_BEEF, 1'b0});
            else n_pass++;
            @(posedge clk); #1;
        end
        ACKD_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata, MREQ} !==
            {1'b1, 2'b00, 32'h0, 1'b0})
            $display("FAIL sh_rsp: got %h want %h",
                     {rsp_valid, rsp_err, rsp_rdata, MREQ},
                     {1'b1, 2'b00, 32'h0, 1'b0});
        else n_pass++;
    endtask

    task automatic test_misaligned;
        logic [1:0]  szs [4] = '{2'b00, 2'b11, 2'b01, 2'b00};
        logic [31:0] ads [4] = '{32'h0800_0002, 32'h0800_0000,
                                 32'h0800_0001, 32'h0800_0001};
        logic        wrs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            ACKD_n = 1'b0;
            send(wrs[k], szs[k], 1'b0, ads[k], 32'hA5A5_A5A5);
            @(negedge clk);
            n_total++;
            if ({rsp_valid, rsp_err, rsp_rdata, MREQ} !==
                {1'b1, 2'b01, 32'h0, 1'b0})
                $display("FAIL misalign_%0d: got %h want %h", k,
                         {rsp_valid, rsp_err, rsp_rdata, MREQ},
                         {1'b1, 2'b01, 32'h0, 1'b0});
            else n_pass++;
            @(posedge clk); #1;
            ACKD_n = 1'b1;
            @(negedge clk);
            n_total++;
            if ({busy, MREQ, rsp_valid} !== 3'b000)
                $display("FAIL misalign_after_%0d: got %b want %b", k,
                         {busy, MREQ, rsp_valid}, 3'b000);
            else n_pass++;
        end
    endtask

    task automatic test_timeout;
        @(posedge clk); #1;
        send(1'b0, 2'b00, 1'b0, 32'h0800_0020, 32'h1111_1111);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            n_total++;
            if ({MREQ, rsp_valid, DAD} !== {1'b1, 1'b0, 32'h0800_0020})
                $display("FAIL tmo_bus_c%0d: got %h want %h", c,
                         {MREQ, rsp_valid, DAD},
                         {1'b1, 1'b0, 32'h0800_0020});
            else n_pass++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata, MREQ} !==
            {1'b1, 2'b10, 32'h0, 1'b0})
            $display("FAIL tmo_rsp: got %h want %h",
                     {rsp_valid, rsp_err, rsp_rdata, MREQ},
                     {1'b1, 2'b10, 32'h0, 1'b0});
        else n_pass++;
        @(posedge clk); #1;
        send(1'b0, 2'b01, 1'b0, 32'h0800_0002, 32'h2222_2222);
        repeat (TO - 1) begin
            @(posedge clk); #1;
        end
        ACKD_n = 1'b0;
        tb_drv = 1'b1;
        tb_ddt = 32'hABCD_8001;
        @(negedge clk);
        n_total++;
        if ({MREQ, rsp_valid} !== 2'b10)
            $display("FAIL tmo_last_cycle: got %b want %b",
                     {MREQ, rsp_valid}, 2'b10);
        else n_pass++;
        @(posedge clk); #1;
        ACKD_n = 1'b1;
        tb_drv = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !==
            {1'b1, 2'b00, 32'hFFFF_8001})
            $display("FAIL tmo_ack_wins: got %h want %h",
                     {rsp_valid, rsp_err, rsp_rdata},
                     {1'b1, 2'b00, 32'hFFFF_8001});
        else n_pass++;
    endtask

    task automatic test_boundary;
        @(posedge clk); #1;
        ACKD_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({busy, rsp_valid, MREQ} !== 3'b000)
            $display("FAIL ack_in_idle: got %b want %b",
                     {busy, rsp_valid, MREQ}, 3'b000);
        else n_pass++;
        @(posedge clk); #1;
        ACKD_n = 1'b1;
        send(1'b0, 2'b00, 1'b1, 32'h0800_0040, 32'h3333_3333);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0900_0000;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                ACKD_n = 1'b0;
                tb_drv = 1'b1;
                tb_ddt = 32'h7654_3210;
            end
            @(negedge clk);
            n_total++;
            if ({MREQ, WRITE, SIZE, DAD} !==
                {1'b1, 1'b0, 2'b00, 32'h0800_0040})
                $display("FAIL busy_ignore_c%0d: got %h want %h", c,
                         {MREQ, WRITE, SIZE, DAD},
                         {1'b1, 1'b0, 2'b00, 32'h0800_0040});
            else n_pass++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        tb_drv = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !==
            {1'b1, 2'b00, 32'h7654_3210})
            $display("FAIL busy_ignore_rsp: got %h want %h",
                     {rsp_valid, rsp_err, rsp_rdata},
                     {1'b1, 2'b00, 32'h7654_3210});
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if ({busy, rsp_valid, MREQ} !== 3'b000)
            $display("FAIL ack_in_resp: got %b want %b",
                     {busy, rsp_valid, MREQ}, 3'b000);
        else n_pass++;
        ACKD_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        send(1'b1, 2'b00, 1'b0, 32'h0800_0100, 32'hCAFE_F00D);
        ACKD_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({MREQ, WRITE, ddt} !== {1'b1, 1'b1, 32'hCAFE_F00D})
            $display("FAIL b2b_first_bus: got %h want %h",
                     {MREQ, WRITE, ddt}, {1'b1, 1'b1, 32'hCAFE_F00D});
        else n_pass++;
        @(posedge clk); #1;
        ACKD_n       = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'b00;
        req_addr     = 32'h0800_0104;
        req_wdata    = 32'h0BAD_BEEF;
        req_valid    = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_err, MREQ} !== {1'b1, 2'b00, 1'b0})
            $display("FAIL b2b_first_rsp: got %b want %b",
                     {rsp_valid, rsp_err, MREQ}, {1'b1, 2'b00, 1'b0});
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if ({busy, MREQ, rsp_valid} !== 3'b000)
            $display("FAIL b2b_idle_gap: got %b want %b",
                     {busy, MREQ, rsp_valid}, 3'b000);
        else n_pass++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ACKD_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({MREQ, DAD, ddt} !== {1'b1, 32'h0800_0104, 32'h0BAD_BEEF})
            $display("FAIL b2b_second_bus: got %h want %h",
                     {MREQ, DAD, ddt},
                     {1'b1, 32'h0800_0104, 32'h0BAD_BEEF});
        else n_pass++;
        @(posedge clk); #1;
        ACKD_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 2'b00, 32'h0})
            $display("FAIL b2b_second_rsp: got %h want %h",
                     {rsp_valid, rsp_err, rsp_rdata},
                     {1'b1, 2'b00, 32'h0});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        send(1'b1, 2'b00, 1'b0, 32'h0800_0010, 32'h0000_BEEF);
        @(negedge clk);
        n_total++;
        if ({MREQ, ddt} !== {1'b1, 32'h0000_BEEF})
            $display("FAIL rstmid_bus: got %h want %h",
                     {MREQ, ddt}, {1'b1, 32'h0000_BEEF});
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({MREQ, WRITE, busy, rsp_valid, DAD} !== 36'h0)
            $display("FAIL rstmid_outputs: got %h want %h",
                     {MREQ, WRITE, busy, rsp_valid, DAD}, 36'h0);
        else n_pass++;
        tb_drv = 1'b1;
        tb_ddt = 32'h1234_0000;
        #1;
        n_total++;
        if (ddt !== 32'h1234_0000)
            $display("FAIL rstmid_ddt_released: got %h want %h",
                     ddt, 32'h1234_0000);
        else n_pass++;
        tb_drv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        send(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'hFFFF_FF41);
        ACKD_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({MREQ, WRITE, SIZE, DAD, ddt} !==
            {1'b1, 1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041})
            $display("FAIL sb_after_rst_bus: got %h want %h",
                     {MREQ, WRITE, SIZE, DAD, ddt},
                     {1'b1, 1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041});
        else n_pass++;
        @(posedge clk); #1;
        ACKD_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 2'b00, 32'h0})
            $display("FAIL sb_after_rst_rsp: got %h want %h",
                     {rsp_valid, rsp_err, rsp_rdata},
                     {1'b1, 2'b00, 32'h0});
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d passed",
                 n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
